// File: rtl/enc_pwm_mixer.sv
// Quadrature encoder to PWM mixer: per-channel debounced detent counters driving a shared-counter PWM.
// Optional macro ENC_SATURATE_EN clamps the counters at 0 and full scale instead of wrapping.
module enc_pwm_mixer #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 4,
    parameter int STEP     = 1,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [CHANNELS-1:0] enc_a,
    input  logic [CHANNELS-1:0] enc_b,
    input  logic [SEL_W-1:0]    debug_sel,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [WIDTH-1:0]    debug_value
);

    // Bits [CHANNELS-1:0] carry A, bits [2*CHANNELS-1:CHANNELS] carry B.
    localparam int              NB      = 2 * CHANNELS;
    localparam logic [7:0]      DB_LAST = 8'(DEBOUNCE - 1);
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] MAX_V  = '1;

    logic [NB-1:0]       sync1_q, sync1_d;
    logic [NB-1:0]       sync2_q, sync2_d;
    logic [NB-1:0]       level_q, level_d;
    logic [7:0]          db_cnt_q [NB];
    logic [7:0]          db_cnt_d [NB];
    logic [CHANNELS-1:0] a_prev_q, a_prev_d;
    logic [WIDTH-1:0]    value_q [CHANNELS];
    logic [WIDTH-1:0]    value_d [CHANNELS];
    logic [WIDTH-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [CHANNELS-1:0] pwm_out_q, pwm_out_d;
    logic [WIDTH-1:0]    debug_q, debug_d;

    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
`ifdef ENC_SATURATE_EN
        logic [WIDTH:0] s;
        s = {1'b0, v} + {1'b0, STEP_V};
        return s[WIDTH] ? MAX_V : s[WIDTH-1:0];
`else
        return v + STEP_V;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] step_dn(input logic [WIDTH-1:0] v);
`ifdef ENC_SATURATE_EN
        return (v < STEP_V) ? '0 : v - STEP_V;
`else
        return v - STEP_V;
`endif
    endfunction

    always_comb begin
        sync1_d  = sync1_q;
        sync2_d  = sync2_q;
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        if (ena) begin
            sync1_d = {enc_b, enc_a};
            sync2_d = sync1_q;
            for (int i = 0; i < NB; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_d[i] = 8'd0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i]  = ~level_q[i];
                    db_cnt_d[i] = 8'd0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // A rise is taken from the registered debounced level, so the value moves one cycle later.
    always_comb begin
        value_d  = value_q;
        a_prev_d = a_prev_q;
        if (ena) begin
            a_prev_d = level_q[CHANNELS-1:0];
            for (int c = 0; c < CHANNELS; c++) begin
                if (level_q[c] && !a_prev_q[c]) begin
                    value_d[c] = level_q[CHANNELS+c] ? step_dn(value_q[c]) : step_up(value_q[c]);
                end
            end
        end
    end

    always_comb begin
        pwm_cnt_d = pwm_cnt_q;
        pwm_out_d = '0;
        debug_d   = debug_q;
        if (ena) begin
            pwm_cnt_d = pwm_cnt_q + WIDTH'(1);
            debug_d   = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                pwm_out_d[c] = (pwm_cnt_q < value_q[c]);
                if (debug_sel == SEL_W'(c)) begin
                    debug_d = value_q[c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            a_prev_q  <= '0;
            pwm_cnt_q <= '0;
            pwm_out_q <= '0;
            debug_q   <= '0;
            for (int i = 0; i < NB; i++) begin
                db_cnt_q[i] <= 8'd0;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                value_q[c] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            a_prev_q  <= a_prev_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwm_out_q <= pwm_out_d;
            debug_q   <= debug_d;
            for (int i = 0; i < NB; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            for (int c = 0; c < CHANNELS; c++) begin
                value_q[c] <= value_d[c];
            end
        end
    end

    assign pwm_out     = pwm_out_q;
    assign debug_value = debug_q;

endmodule

// File: tb/tb_enc_pwm_mixer.sv
// Bench for enc_pwm_mixer: cycle-level behavioural model compared every cycle, plus literal checks.
module tb_enc_pwm_mixer;
    localparam int CH   = 3;
    localparam int W    = 8;
    localparam int DB   = 4;
    localparam int STEP = 1;
    localparam int MAXV = 255;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic [CH-1:0] enc_a = '0;
    logic [CH-1:0] enc_b = '0;
    logic [1:0]    debug_sel = '0;
    logic [CH-1:0] pwm_out;
    logic [W-1:0]  debug_value;

    int n_checks = 0;
    int n_fail   = 0;
    int hi;
    int k;
    bit chk_en = 0;

    always #5 clk = ~clk;

    enc_pwm_mixer #(.CHANNELS(CH), .WIDTH(W), .DEBOUNCE(DB), .STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .enc_a(enc_a), .enc_b(enc_b),
        .debug_sel(debug_sel), .pwm_out(pwm_out), .debug_value(debug_value)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pins reach the debouncer two clocks late; a level is accepted
    // once the last DB synchronised samples all disagree with it.
    int               m_val [CH];
    int               m_cnt;
    bit               m_lvl [2*CH];
    bit               m_prev [CH];
    logic [2*CH-1:0]  m_pipe [$];
    bit               m_hist [2*CH][$];
    logic [CH-1:0]    exp_pwm;
    int               exp_dbg;

    function automatic int apply_step(input int v, input bit down);
`ifdef ENC_SATURATE_EN
        if (down) return (v - STEP < 0) ? 0 : v - STEP;
        return (v + STEP > MAXV) ? MAXV : v + STEP;
`else
        if (down) return (v - STEP + 256) % 256;
        return (v + STEP) % 256;
`endif
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_val[c]  = 0;
            m_prev[c] = 0;
        end
        for (int i = 0; i < 2*CH; i++) begin
            m_lvl[i] = 0;
            m_hist[i].delete();
        end
        m_pipe.delete();
        m_pipe.push_back('0);
        m_pipe.push_back('0);
        m_cnt   = 0;
        exp_pwm = '0;
        exp_dbg = 0;
    endtask

    task automatic model_step();
        logic [2*CH-1:0] smp;
        bit flip;
        exp_dbg = (debug_sel < CH) ? m_val[debug_sel] : 0;
        for (int c = 0; c < CH; c++) exp_pwm[c] = (m_cnt < m_val[c]);
        for (int c = 0; c < CH; c++)
            if (m_lvl[c] && !m_prev[c]) m_val[c] = apply_step(m_val[c], m_lvl[CH+c]);
        for (int c = 0; c < CH; c++) m_prev[c] = m_lvl[c];
        smp = m_pipe.pop_front();
        m_pipe.push_back({enc_b, enc_a});
        for (int i = 0; i < 2*CH; i++) begin
            m_hist[i].push_back(smp[i]);
            if (m_hist[i].size() > DB) void'(m_hist[i].pop_front());
            if (m_hist[i].size() == DB) begin
                flip = 1;
                for (int j = 0; j < DB; j++) if (m_hist[i][j] == m_lvl[i]) flip = 0;
                if (flip) m_lvl[i] = !m_lvl[i];
            end
        end
        m_cnt = (m_cnt + 1) % 256;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else if (ena) model_step();
            else exp_pwm = '0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                check("pwm_out_vs_model", pwm_out, exp_pwm);
                check("debug_value_vs_model", debug_value, exp_dbg);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic detent(input logic [CH-1:0] mask, input logic [CH-1:0] ccw);
        enc_b = (enc_b & ~mask) | (ccw & mask); idle(8);
        enc_a = enc_a | mask;                   idle(8);
        enc_a = enc_a & ~mask;                  idle(8);
        enc_b = enc_b & ~mask;                  idle(8);
    endtask

    task automatic check_val(input string name, input int ch, input int exp);
        debug_sel = 2'(ch);
        idle(2);
        check(name, debug_value, exp);
    endtask

    task automatic count_pwm(input int c, output int n);
        n = 0;
        repeat (256) begin
            @(negedge clk);
            #1;
            n += int'(pwm_out[c]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
    endtask

    initial begin
        idle(2);
        check("reset_pwm", pwm_out, 0);
        check("reset_dbg", debug_value, 0);
        chk_en = 1;
        rst_n  = 1'b1;
        ena    = 1'b1;
        idle(2);

        repeat (10) detent(3'b001, 3'b000);
        check_val("ch0_after_10_cw", 0, 10);
        check_val("ch1_untouched", 1, 0);
        check_val("ch2_untouched", 2, 0);
        check_val("sel_out_of_range", 3, 0);
        count_pwm(0, hi); check("pwm0_duty_10", hi, 10);
        count_pwm(1, hi); check("pwm1_duty_0", hi, 0);

        enc_a[1] = 1'b1; idle(2); enc_a[1] = 1'b0; idle(20);
        check_val("glitch_ch1", 1, 0);
        enc_a[1] = 1'b1; idle(4); enc_a[1] = 1'b0; idle(20);
        check_val("pulse4_ch1", 1, 1);

        detent(3'b100, 3'b100);
`ifdef ENC_SATURATE_EN
        check_val("dec_from_0", 2, 0);
        repeat (255) detent(3'b100, 3'b000);
        check_val("count_to_255", 2, 255);
        detent(3'b100, 3'b000);
        check_val("inc_from_255", 2, 255);
`else
        check_val("dec_from_0", 2, 255);
        detent(3'b100, 3'b000);
        check_val("inc_from_255_wraps", 2, 0);
`endif

        do_reset();
        repeat (5) detent(3'b101, 3'b000);
        check_val("ch0_five", 0, 5);
        check_val("ch2_five", 2, 5);
        detent(3'b101, 3'b100);
        check_val("simul_ch0_plus", 0, 6);
        check_val("simul_ch2_minus", 2, 4);

        do_reset();
        repeat (25) detent(3'b111, 3'b000);
        repeat (25) detent(3'b011, 3'b000);
        repeat (50) detent(3'b001, 3'b000);
        check_val("ch0_100", 0, 100);
        check_val("ch1_50", 1, 50);
        check_val("ch2_25", 2, 25);
        debug_sel = 2'd0;
        k = 0;
        while (!pwm_out[0] && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("pwm0_high_before_reset", pwm_out[0], 1);
        enc_a[0] = 1'b1;
        idle(2);
        rst_n = 1'b0;
        #1;
        check("reset_forces_pwm", pwm_out, 0);
        check("reset_forces_dbg", debug_value, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check_val("ch0_after_reset", 0, 0);
        check_val("ch1_after_reset", 1, 0);
        check_val("ch2_after_reset", 2, 0);
        idle(20);
        check_val("a_high_at_release_one_detent", 0, 1);
        enc_a[0] = 1'b0;
        idle(12);

        do_reset();
        repeat (3) detent(3'b001, 3'b000);
        debug_sel = 2'd0;
        idle(2);
        ena = 1'b0;
        repeat (5) detent(3'b001, 3'b000);
        count_pwm(0, hi); check("pwm0_low_while_disabled", hi, 0);
        check_val("dbg_held_while_disabled", 2, 3);
        debug_sel = 2'd0;
        ena = 1'b1;
        idle(2);
        check_val("ch0_unchanged_after_enable", 0, 3);
        count_pwm(0, hi); check("pwm0_duty_resumes", hi, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        n_fail++;
        $display("FAIL watchdog: test did not complete, got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
